// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared types and encodings for the RV32I multi-cycle controller:
//   - controller state enum
//   - base opcode constants (IR[6:0])
//   - datapath select encodings (imm_src, alu_src_a/b, alu_op, result_src)
//   - imm_sel(): opcode -> immediate format
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_AUIPC,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_ERR
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // Immediate format for the instruction in IR; unknown opcodes fall
    // back to the I format (value is irrelevant for them).
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:         imm_sel = IMM_S;
            OP_BRANCH:        imm_sel = IMM_B;
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            OP_JAL:           imm_sel = IMM_J;
            default:          imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// branch_cond
// Combinational branch resolution from the ALU flags of rs1-rs2.
//   funct3   in  3  branch kind (IR[14:12])
//   zero     in  1  ALU result == 0
//   lt       in  1  signed rs1 < rs2
//   ltu      in  1  unsigned rs1 < rs2
//   taken    out 1  branch taken
// funct3 010/011 are not branch encodings and resolve as not taken.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Sequencer for the shared RV32I multi-cycle datapath (PC, IR, regfile,
// ImmExt, ALU, one unified memory port). Decodes IR's opcode and drives
// every select/strobe per cycle, runs the mem_valid/mem_ready handshake
// and a wait timeout that parks the FSM in ERR with a sticky bus_err.
//
// Parameter:
//   MEM_WAIT_MAX  cycles mem_valid may wait for mem_ready; 0 = no timeout
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   opcode, funct3, funct7_5   IR fields
//   zero, lt, ltu              ALU flags
//   mem_ready                  memory completes the access this cycle
//   mem_valid, mem_we, adr_src memory request, store, address select
//   ir_write, pc_write, reg_write  write strobes
//   imm_src, alu_src_a, alu_src_b, alu_op, result_src  datapath selects
//   bus_err                    sticky memory timeout
//   trap                       sticky illegal opcode
//
// Build option: ILLEGAL_TRAP_EN -- when defined an unknown opcode sends
// the FSM to ERR with trap set; otherwise it executes as a NOP and trap
// is tied low.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_valid,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       bus_err,
    output logic       trap
);
    import riscv_ctrl_pkg::*;

    // Counter only needs to hold 0..MEM_WAIT_MAX-1: the increment that
    // would reach the limit is the one that moves the FSM to ERR.
    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT =
        CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          bus_err_q;
    logic          wait_hit;
    logic          taken;

    logic       mem_valid_c, mem_we_c, adr_src_c;
    logic       ir_write_c, pc_write_c, reg_write_c;
    logic [2:0] imm_src_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;

`ifdef ILLEGAL_TRAP_EN
    logic illegal;
    logic trap_q;
`endif

    // funct7_5 is consumed by the datapath's ALU decoder (alu_op = 2);
    // the sequencer itself never needs it.
    logic ctrl_unused;
    assign ctrl_unused = funct7_5;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        mem_valid_c  = 1'b0;
        mem_we_c     = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        imm_src_c    = imm_sel(opcode);
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALU_ADD;
        result_src_c = RES_ALUOUT;
`ifdef ILLEGAL_TRAP_EN
        illegal      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC on completion
                mem_valid_c  = 1'b1;
                alu_src_a_c  = SRCA_PC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALU;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // precompute the branch/JAL target into ALUOut
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        illegal    = 1'b1;
                        state_next = S_ERR;
`else
                        state_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_next  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_valid_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = RES_MEM;
                reg_write_c  = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_valid_c = 1'b1;
                mem_we_c    = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALU_FUNCT;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALU_FUNCT;
                state_next  = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a_c = SRCA_ZERO;
                alu_src_b_c = SRCB_IMM;
                state_next  = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                // compare rs1-rs2 while ALUOut still holds the target
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_RS2;
                alu_op_c     = ALU_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = taken;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                // target from DECODE goes to PC; ALU forms the link value
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
                state_next   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_IMM;
                result_src_c = RES_ALU;
                pc_write_c   = 1'b1;
                state_next   = S_LINK;
            end
            S_LINK: begin
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALU;
                reg_write_c  = 1'b1;
                state_next   = S_FETCH;
            end
            S_ERR: begin
                imm_src_c  = 3'd0;
                state_next = S_ERR;
            end
            default: state_next = S_FETCH;
        endcase

        // Timeout only fires on a cycle without mem_ready, so a ready
        // arriving on the limit cycle completes the access instead.
        wait_hit = (MEM_WAIT_MAX != 0) && mem_valid_c && !mem_ready &&
                   (wait_cnt == WAIT_LIMIT);
        if (wait_hit) state_next = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_next != state || mem_ready) wait_cnt <= '0;
            else if (mem_valid_c)                 wait_cnt <= wait_cnt + 1'b1;
            if (wait_hit) bus_err_q <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       trap_q <= 1'b0;
        else if (illegal) trap_q <= 1'b1;
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Reset gates every output so an in-flight request drops at once.
    assign mem_valid  = rst_n & mem_valid_c;
    assign mem_we     = rst_n & mem_we_c;
    assign adr_src    = rst_n & adr_src_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign reg_write  = rst_n & reg_write_c;
    assign imm_src    = rst_n ? imm_src_c    : 3'd0;
    assign alu_src_a  = rst_n ? alu_src_a_c  : 2'd0;
    assign alu_src_b  = rst_n ? alu_src_b_c  : 2'd0;
    assign alu_op     = rst_n ? alu_op_c     : 2'd0;
    assign result_src = rst_n ? result_src_c : 2'd0;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed checks for reset, async reset mid-access, timeout and illegal
// opcode, then a randomized instruction stream. The stream's expected
// strobe events (cycle number + observable selects) come from a per-
// instruction latency model and are queued; a monitor pops and compares
// whenever the DUT fires a strobe or completes a memory access.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_BR    = 7'b1100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_AUIPC = 7'b0010111;
    localparam int         N_INSTR = 80;

    typedef struct {
        int       cyc;
        bit       ir, pc, rw, md, we, adr;
        bit [1:0] rs;
        bit       rs_care;
        bit [1:0] a, b, op;
        bit       alu_care;
        bit [2:0] imm;
        bit       imm_care;
    } ev_t;

    typedef struct {
        bit [6:0] op;
        bit [2:0] f3;
        bit       f7, z, l, lu;
        int       wf, wm;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, zero, lt, ltu, mem_ready;
    logic       mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       bus_err, trap;
    logic [18:0] outs;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    ev_t  sbq[$];
    ins_t pq[$];
    ev_t  act, exp_e;

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .bus_err(bus_err), .trap(trap)
    );

    assign outs = {mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write,
                   imm_src, alu_src_a, alu_src_b, alu_op, result_src,
                   bus_err, trap};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic bit [2:0] imm_of(input bit [6:0] op);
        case (op)
            T_STORE:        return 3'd1;
            T_BR:           return 3'd2;
            T_LUI, T_AUIPC: return 3'd3;
            T_JAL:          return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    function automatic bit known(input bit [6:0] op);
        return op inside {T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR,
                          T_LUI, T_AUIPC};
    endfunction

    function automatic bit br_taken(input ins_t i);
        case (i.f3)
            3'd0: return i.z;
            3'd1: return !i.z;
            3'd4: return i.l;
            3'd5: return !i.l;
            3'd6: return i.lu;
            3'd7: return !i.lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ev_t mk(input int c, input bit [6:0] op);
        ev_t e;
        e = '{default: 0};
        e.cyc = c;
        e.imm = imm_of(op);
        e.imm_care = known(op);
        return e;
    endfunction

    function automatic ins_t gen();
        ins_t i;
        int   k;
`ifdef ILLEGAL_TRAP_EN
        k = $urandom_range(0, 8);
`else
        k = $urandom_range(0, 9);
`endif
        case (k)
            0: i.op = T_LOAD;  1: i.op = T_STORE; 2: i.op = T_R;
            3: i.op = T_I;     4: i.op = T_BR;    5: i.op = T_JAL;
            6: i.op = T_JALR;  7: i.op = T_LUI;   8: i.op = T_AUIPC;
            default: i.op = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h7f;
        endcase
        i.f3 = 3'($urandom_range(0, 7));
        i.f7 = 1'($urandom_range(0, 1));
        i.z  = 1'($urandom_range(0, 1));
        i.l  = 1'($urandom_range(0, 1));
        i.lu = 1'($urandom_range(0, 1));
        i.wf = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
        i.wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
        return i;
    endfunction

    // Expected events for one instruction whose fetch starts at cycle t;
    // returns the first cycle of the next fetch.
    function automatic int model(input ins_t i, input bit [6:0] prev, input int t);
        ev_t e;
        int  d;
        e = mk(t + i.wf, prev);
        e.ir = 1; e.pc = 1; e.md = 1; e.adr = 0;
        e.rs = 2; e.rs_care = 1; e.a = 0; e.b = 2; e.op = 0; e.alu_care = 1;
        sbq.push_back(e);
        d = t + i.wf + 1;
        case (i.op)
            T_LOAD: begin
                e = mk(d + 2 + i.wm, i.op); e.md = 1; e.adr = 1; sbq.push_back(e);
                e = mk(d + 3 + i.wm, i.op); e.rw = 1; e.rs = 1; e.rs_care = 1;
                sbq.push_back(e);
                return d + 4 + i.wm;
            end
            T_STORE: begin
                e = mk(d + 2 + i.wm, i.op); e.md = 1; e.we = 1; e.adr = 1;
                sbq.push_back(e);
                return d + 3 + i.wm;
            end
            T_R, T_I, T_LUI, T_AUIPC: begin
                e = mk(d + 2, i.op); e.rw = 1; e.rs = 0; e.rs_care = 1;
                sbq.push_back(e);
                return d + 3;
            end
            T_JAL: begin
                e = mk(d + 1, i.op); e.pc = 1; e.rs = 0; e.rs_care = 1;
                e.a = 1; e.b = 2; e.op = 0; e.alu_care = 1; sbq.push_back(e);
                e = mk(d + 2, i.op); e.rw = 1; e.rs = 0; e.rs_care = 1;
                sbq.push_back(e);
                return d + 3;
            end
            T_JALR: begin
                e = mk(d + 1, i.op); e.pc = 1; e.rs = 2; e.rs_care = 1;
                e.a = 2; e.b = 1; e.op = 0; e.alu_care = 1; sbq.push_back(e);
                e = mk(d + 2, i.op); e.rw = 1; e.rs = 2; e.rs_care = 1;
                e.a = 1; e.b = 2; e.op = 0; e.alu_care = 1; sbq.push_back(e);
                return d + 3;
            end
            T_BR: begin
                if (br_taken(i)) begin
                    e = mk(d + 1, i.op); e.pc = 1; e.rs = 0; e.rs_care = 1;
                    e.a = 2; e.b = 0; e.op = 1; e.alu_care = 1; sbq.push_back(e);
                end
                return d + 2;
            end
            default: return d + 1;
        endcase
    endfunction

    // Observable fields of x, keeping only what event m says matters.
    function automatic logic [31:0] pack(input ev_t x, input ev_t m);
        return 32'({x.ir, x.pc, x.rw, x.md, x.we,
                    m.md ? x.adr : 1'b0,
                    m.rs_care ? x.rs : 2'd0,
                    m.alu_care ? {x.a, x.b, x.op} : 6'd0,
                    m.imm_care ? x.imm : 3'd0});
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            if (ir_write || pc_write || reg_write || (mem_valid && mem_ready)) begin
                act = '{default: 0};
                act.cyc = cyc;
                act.ir = ir_write; act.pc = pc_write; act.rw = reg_write;
                act.md = mem_valid && mem_ready; act.we = mem_we; act.adr = adr_src;
                act.rs = result_src; act.a = alu_src_a; act.b = alu_src_b;
                act.op = alu_op; act.imm = imm_src;
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL ev_unexpected: strobe event at cycle %0d, none expected", cyc);
                end else begin
                    exp_e = sbq.pop_front();
                    chk("ev_cycle", cyc, exp_e.cyc);
                    chk("ev_signals", pack(act, exp_e), pack(exp_e, exp_e));
                    chk("ev_sticky", 32'({bus_err, trap}), 0);
                end
            end
        end
    end

    // ---------------- memory / IR responder ----------------
    task automatic serve(input int w);
        int n = 0;
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (mem_valid) begin
                if (n == w) begin
                    mem_ready = 1'b1;
                    @(posedge clk);
                    #1 mem_ready = 1'b0;
                    done = 1;
                end else n++;
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL serve_timeout: no mem_valid access completed, wanted %0d waits", w);
        end
    endtask

    task automatic run_prog();
        ins_t i;
        while (pq.size() > 0) begin
            i = pq.pop_front();
            serve(i.wf);
            opcode = i.op; funct3 = i.f3; funct7_5 = i.f7;
            zero = i.z; lt = i.l; ltu = i.lu;
            if (i.op == T_LOAD || i.op == T_STORE) serve(i.wm);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int   t;
        ins_t i;
        bit [6:0] prev;

        rst_n = 0; mem_ready = 0; opcode = T_BR; funct3 = 0; funct7_5 = 0;
        zero = 0; lt = 0; ltu = 0;
        repeat (2) @(posedge clk);
        #2 chk("rst_outputs", 32'(outs), 0);

        // LW fetch/decode, then reset while in MEMREAD
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); #2 chk("rel_fetch", 32'({mem_valid, adr_src}), 2);
        mem_ready = 1;
        #1 chk("fetch_strobes", 32'({ir_write, pc_write}), 3);
        @(posedge clk); #1 mem_ready = 0; opcode = T_LOAD;
        @(negedge clk); #2 chk("lw_decode_imm", 32'(imm_src), 0);
        @(negedge clk); #2 chk("lw_memadr", 32'({alu_src_a, alu_src_b}), 32'h9);
        @(negedge clk); #2 chk("lw_memread", 32'({mem_valid, adr_src, mem_we}), 6);
        #1 rst_n = 0;
        #1 chk("rst_async", 32'(outs), 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); #2 chk("fetch_after_rst", 32'({mem_valid, adr_src}), 2);

        // mem_ready never comes: 15 wait cycles, then ERR
        repeat (14) @(negedge clk);
        #2 chk("tmo_last_wait", 32'({mem_valid, bus_err}), 2);
        @(negedge clk);
        #2 chk("tmo_err", 32'({mem_valid, bus_err, ir_write, pc_write, reg_write}), 8);
        mem_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2 chk("err_hold", 32'({mem_valid, bus_err, ir_write, pc_write}), 4);
        end
        mem_ready = 0;

        // illegal opcode 0000000
        @(negedge clk); rst_n = 0; opcode = T_I;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); #2 mem_ready = 1;
        @(posedge clk); #1 mem_ready = 0; opcode = 7'h00;
        @(negedge clk); #2 chk("ill_decode", 32'({trap, bus_err}), 0);
`ifdef ILLEGAL_TRAP_EN
        @(negedge clk); #2 chk("ill_trap_err", 32'({trap, mem_valid, bus_err}), 4);
        @(negedge clk); #2 chk("ill_trap_hold", 32'({trap, mem_valid}), 2);
`else
        @(negedge clk); #2 chk("ill_nop_fetch", 32'({trap, mem_valid, adr_src}), 2);
`endif

        // randomized stream
        @(negedge clk); rst_n = 0; mem_ready = 0; opcode = T_I;
        for (int k = 0; k < N_INSTR; k++) begin
            i = gen();
            pq.push_back(i);
        end
        @(posedge clk); #1 rst_n = 1;
        t = cyc;
        prev = T_I;
        foreach (pq[k]) begin
            t = model(pq[k], prev, t);
            prev = pq[k].op;
        end
        mon_en = 1;
        fork
            run_prog();
        join_none

        for (int k = 0; k < 20000 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_chk++;
            $display("FAIL sb_drain: %0d expected events never seen", sbq.size());
        end
        repeat (6) @(negedge clk);
        mon_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state controller that sequences the shared RV32I multi-cycle datapath: PC, IR, register file, ImmExt, ALU and a single unified memory port. It decodes the opcode held in IR and drives every datapath select and write strobe cycle by cycle. It also runs the memory request/ready handshake and a wait-timeout. It sits beside the datapath in the core top level.

## Interface
- MEM_WAIT_MAX, 15, cycles `mem_valid` may stay high without `mem_ready` before bus error; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero, lt, ltu  in  1 each  ALU flags of current ALU result
- mem_ready  in  1  memory completes the current access this cycle
- mem_valid  out  1  memory access request
- mem_we  out  1  store when high
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write, pc_write, reg_write  out  1 each  write strobes
- imm_src  out  3  0 I, 1 S, 2 B, 3 U, 4 J
- alu_src_a  out  2  0 PC, 1 oldPC, 2 rs1, 3 zero
- alu_src_b  out  2  0 rs2, 1 imm, 2 const 4
- alu_op  out  2  0 add, 1 sub, 2 funct-decoded (funct3/funct7_5)
- result_src  out  2  0 ALUOut, 1 mem data, 2 ALU result
- bus_err  out  1  sticky memory timeout
- trap  out  1  sticky illegal opcode

## Operation
- `imm_src` is decoded combinationally from `opcode` in every state.
- States:
  - FETCH: `mem_valid`=1, `adr_src`=0, ALU PC+4 with `result_src`=2. Holds until `mem_ready`. On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE.
  - DECODE: ALU oldPC+imm into ALUOut (branch/JAL target). Dispatch:
    - load/store → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - branch → BRANCH
    - JAL → JAL
    - JALR → JALR
    - LUI → LUI
    - AUIPC → AUIPC
  - MEMADR: rs1+imm. Load → MEMREAD; store → MEMWRITE.
  - MEMREAD: `mem_valid`=1, `adr_src`=1. On `mem_ready` → MEMWB.
  - MEMWB: `result_src`=1, `reg_write`=1 → FETCH.
  - MEMWRITE: `mem_valid`=1, `mem_we`=1, `adr_src`=1. On `mem_ready` → FETCH.
  - EXECR: rs1 op rs2, `alu_op`=2 → ALUWB.
  - EXECI: rs1 op imm, `alu_op`=2 → ALUWB.
  - LUI: zero+imm → ALUWB.
  - AUIPC: oldPC+imm → ALUWB.
  - ALUWB: `result_src`=0, `reg_write`=1 → FETCH.
  - BRANCH: rs1−rs2, `alu_op`=1. `pc_write` = taken, with `result_src`=0 → FETCH. Taken per funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. funct3 010/011 is treated as not taken.
  - JAL: `pc_write`=1 with `result_src`=0; ALU oldPC+4 → ALUWB.
  - JALR: rs1+imm, `result_src`=2, `pc_write`=1 → LINK.
  - LINK: oldPC+4, `result_src`=2, `reg_write`=1 → FETCH.
  - ERR: all strobes 0, `mem_valid`=0. Exits only on reset.
- Wait counter:
  - Counts cycles with `mem_valid`=1 and `mem_ready`=0.
  - Clears on `mem_ready` and on every state change.
  - When it reaches MEM_WAIT_MAX (nonzero) → ERR, `bus_err`=1.
  - `mem_ready` in the same cycle the limit is hit wins: the access completes.

## Timing
- Outputs are combinational from state, plus `mem_ready`/flags for the Mealy strobes (`ir_write`, FETCH `pc_write`, BRANCH `pc_write`).
- While `rst_n`=0: state=FETCH, counter=0, `bus_err`=0, `trap`=0, all outputs forced 0. The first `mem_valid` appears in the first cycle after release.
- Reset asserted mid-access drops `mem_valid` asynchronously.
- Latency with zero-wait memory (cycles):
  - load 5
  - store, R, I, JAL, LUI, AUIPC, JALR 4
  - branch 3
- Each memory wait cycle adds exactly one cycle.

## Configuration
- ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE → ERR with `trap`=1, sticky.
- ILLEGAL_TRAP_EN undefined: an unrecognised opcode is a NOP (DECODE → FETCH) and `trap` is tied 0.

## Structure
- Package `riscv_ctrl_pkg`:
  - state enum
  - opcode constants
  - imm_src, alu_src_a/b, alu_op and result_src encodings
- Sub-module `branch_cond`: funct3, zero, lt, ltu → taken (combinational).

## Test plan
- Reset asserted while in MEMREAD → all outputs 0 immediately. After release, cycle 1 shows FETCH with `mem_valid`=1, `adr_src`=0.
- ADDI (opcode 0010011) with `mem_ready` delayed 2 cycles → FETCH 3 cycles, DECODE, EXECI, then ALUWB with `reg_write`=1 in cycle 6.
- LW (0000011, `mem_ready` immediate) → `imm_src`=0, MEMREAD `adr_src`=1, MEMWB `result_src`=1 with `reg_write`=1; next FETCH at cycle 6.
- BEQ (1100011, funct3 000): `zero`=1 → `pc_write`=1, `imm_src`=2. `zero`=0 → `pc_write`=0; both paths return to FETCH after 3 cycles.
- MEM_WAIT_MAX=15, `mem_ready` held 0 in FETCH → ERR after 15 wait cycles, `bus_err`=1 and `mem_valid`=0 held until reset.
- Opcode 0000000 → `trap`=1 and ERR with ILLEGAL_TRAP_EN defined; without it, FETCH follows DECODE and `trap`=0.
